// File: rtl/entity_motion.sv
// Per-entity tile-grid motion engine: GROUND/RISE/FALL kinematics, wall bounce, ceiling bonk, floor snap.
// Optional jump buffering enabled by defining ENTITY_JUMP_BUFFER_EN.
module entity_motion #(
    parameter int POS_W     = 10,
    parameter int SPD_W     = 5,
    parameter int TILE_LOG2 = 5,
    parameter int ORIGIN_X  = 144,
    parameter int ORIGIN_Y  = 35,
    parameter int SPAWN_X   = 176,
    parameter int SPAWN_Y   = 99,
    parameter int X_SPEED   = 2,
    parameter int JUMP_SPD  = 9,
    parameter int MAX_FALL  = 15,
    parameter int GRAV_DIV  = 1,
    parameter int JUMP_BUF  = 4
) (
    input  logic                         sim_clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [3:0]                   col,
    input  logic                         jump,
    input  logic                         respawn,
    output logic [2*POS_W+2*SPD_W+1:0]   state,
    output logic [1:0]                   mode,
    output logic                         landed
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } mode_t;

    localparam int GC_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GRAV_DIV - 1);
    localparam logic [POS_W-1:0] TILE    = POS_W'(1 << TILE_LOG2);
    localparam logic [POS_W-1:0] TMASK   = TILE - POS_W'(1);
    localparam logic [POS_W-1:0] OX      = POS_W'(ORIGIN_X);
    localparam logic [POS_W-1:0] OY      = POS_W'(ORIGIN_Y);
    localparam logic [POS_W-1:0] SX      = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0] SY      = POS_W'(SPAWN_Y);
    localparam logic [SPD_W-1:0] XS      = SPD_W'(X_SPEED);
    localparam logic [SPD_W-1:0] JS      = SPD_W'(JUMP_SPD);
    localparam logic [SPD_W-1:0] MF      = SPD_W'(MAX_FALL);

    logic [POS_W-1:0] x_q, x_d, y_q, y_d;
    logic [SPD_W-1:0] xspd_q, xspd_d, yspd_q, yspd_d;
    logic             xdir_q, xdir_d, ydir_q, ydir_d;
    mode_t            mode_q, mode_d;
    logic             landed_q, landed_d;
    logic [GC_W-1:0]  gcnt_q, gcnt_d;

    logic [POS_W-1:0] xn, yn, xfrac, yfrac;
    logic             g;
    logic             jump_gnd, land_jump, jump_used;

`ifdef ENTITY_JUMP_BUFFER_EN
    localparam int JB_W = $clog2(JUMP_BUF + 1);
    logic [JB_W-1:0] jbuf_q, jbuf_d;
    logic            buf_hit;
`endif

    always_ff @(posedge sim_clk) begin
        if (reset) begin
            x_q      <= SX;
            y_q      <= SY;
            xspd_q   <= XS;
            yspd_q   <= '0;
            xdir_q   <= 1'b1;
            ydir_q   <= 1'b0;
            mode_q   <= FALL;
            landed_q <= 1'b0;
            gcnt_q   <= '0;
`ifdef ENTITY_JUMP_BUFFER_EN
            jbuf_q   <= '0;
`endif
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xspd_q   <= xspd_d;
            yspd_q   <= yspd_d;
            xdir_q   <= xdir_d;
            ydir_q   <= ydir_d;
            mode_q   <= mode_d;
            landed_q <= landed_d;
            gcnt_q   <= gcnt_d;
`ifdef ENTITY_JUMP_BUFFER_EN
            jbuf_q   <= jbuf_d;
`endif
        end
    end

    always_comb begin
        xn    = xdir_q ? x_q + POS_W'(xspd_q) : x_q - POS_W'(xspd_q);
        yn    = ydir_q ? y_q - POS_W'(yspd_q) : y_q + POS_W'(yspd_q);
        xfrac = (xn - OX) & TMASK;
        yfrac = (yn - OY) & TMASK;
        g     = tick && (gcnt_q == GC_LAST);

        x_d       = x_q;
        y_d       = y_q;
        xspd_d    = xspd_q;
        yspd_d    = yspd_q;
        xdir_d    = xdir_q;
        ydir_d    = ydir_q;
        mode_d    = mode_q;
        landed_d  = 1'b0;
        gcnt_d    = gcnt_q;
        jump_used = 1'b0;
        jump_gnd  = jump;
        land_jump = 1'b0;

`ifdef ENTITY_JUMP_BUFFER_EN
        buf_hit   = (jbuf_q != '0);
        jump_gnd  = jump | buf_hit;
        land_jump = jump | buf_hit;
        jbuf_d    = jbuf_q;
        if (tick) begin
            if (mode_q != GROUND && jump)
                jbuf_d = JB_W'(JUMP_BUF);
            else if (buf_hit)
                jbuf_d = jbuf_q - JB_W'(1);
        end
`endif

        if (tick) begin
            gcnt_d = g ? '0 : gcnt_q + GC_W'(1);
            y_d    = yn;

            // Snap uses the pre-flip direction: the wall we ran into decides which tile edge to hug.
            if (col[0] | col[2]) begin
                xdir_d = ~xdir_q;
                x_d    = xdir_q ? xn - xfrac - POS_W'(1) : xn + (TILE - xfrac);
            end else begin
                x_d = xn;
            end

            case (mode_q)
                GROUND: begin
                    yspd_d = '0;
                    ydir_d = 1'b0;
                    if (jump_gnd) begin
                        mode_d    = RISE;
                        yspd_d    = JS;
                        ydir_d    = 1'b1;
                        jump_used = 1'b1;
                    end else if (!col[1]) begin
                        mode_d = FALL;
                    end
                end
                RISE: begin
                    if (col[3]) begin
                        y_d    = yn + (TILE - yfrac);
                        yspd_d = '0;
                        ydir_d = 1'b0;
                        mode_d = FALL;
                    end else if (g) begin
                        if (yspd_q <= SPD_W'(1)) begin
                            yspd_d = '0;
                            ydir_d = 1'b0;
                            mode_d = FALL;
                        end else begin
                            yspd_d = yspd_q - SPD_W'(1);
                        end
                    end
                end
                FALL: begin
                    if (col[1]) begin
                        y_d      = yn - yfrac - POS_W'(1);
                        yspd_d   = '0;
                        ydir_d   = 1'b0;
                        landed_d = 1'b1;
                        mode_d   = GROUND;
                        if (land_jump) begin
                            mode_d    = RISE;
                            yspd_d    = JS;
                            ydir_d    = 1'b1;
                            jump_used = 1'b1;
                        end
                    end else if (g) begin
                        yspd_d = (yspd_q >= MF) ? MF : yspd_q + SPD_W'(1);
                    end
                end
                default: mode_d = FALL;
            endcase

`ifdef ENTITY_JUMP_BUFFER_EN
            if (jump_used)
                jbuf_d = '0;
`endif

            if (respawn) begin
                x_d      = SX;
                y_d      = SY;
                xspd_d   = XS;
                yspd_d   = '0;
                xdir_d   = 1'b1;
                ydir_d   = 1'b0;
                mode_d   = FALL;
                landed_d = 1'b0;
                gcnt_d   = '0;
`ifdef ENTITY_JUMP_BUFFER_EN
                jbuf_d   = '0;
`endif
            end
        end
    end

    assign state  = {x_q, y_q, xspd_q, yspd_q, xdir_q, ydir_q};
    assign mode   = mode_q;
    assign landed = landed_q;

endmodule

// File: tb/tb_entity_motion.sv
// Directed-vector bench for entity_motion at default parameters.
module tb_entity_motion;

    logic        sim_clk = 1'b0;
    logic        reset;
    logic        tick;
    logic [3:0]  col;
    logic        jump;
    logic        respawn;
    logic [31:0] state;
    logic [1:0]  mode;
    logic        landed;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [9:0] x, y;
    logic [4:0] xspd, yspd;
    logic       xdir, ydir;

    assign x    = state[31:22];
    assign y    = state[21:12];
    assign xspd = state[11:7];
    assign yspd = state[6:2];
    assign xdir = state[1];
    assign ydir = state[0];

    entity_motion dut (
        .sim_clk (sim_clk),
        .reset   (reset),
        .tick    (tick),
        .col     (col),
        .jump    (jump),
        .respawn (respawn),
        .state   (state),
        .mode    (mode),
        .landed  (landed)
    );

    always #5 sim_clk = ~sim_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] c, input logic j, input logic r, input logic t);
        @(negedge sim_clk);
        tick    = t;
        col     = c;
        jump    = j;
        respawn = r;
        @(posedge sim_clk);
        #1;
        tick    = 1'b0;
        col     = '0;
        jump    = 1'b0;
        respawn = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey, input int eys, input int em);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".yspd"}, 32'(yspd), 32'(eys));
        chk({tag, ".mode"}, 32'(mode), 32'(em));
    endtask

    initial begin
        int exp_spd;
        int exp_y;
        reset = 1'b1; tick = 1'b0; col = '0; jump = 1'b0; respawn = 1'b0;
        repeat (3) @(posedge sim_clk);
        #1;
        reset = 1'b0;
        chk_pos("rst", 176, 99, 0, 2);
        chk("rst.xspd", 32'(xspd), 32'd2);
        chk("rst.xdir", 32'(xdir), 32'd1);
        chk("rst.ydir", 32'(ydir), 32'd0);
        chk("rst.landed", 32'(landed), 32'd0);

        // first tick: gravity applies, y moves by the old (zero) speed
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        chk_pos("t1", 178, 99, 1, 2);
        repeat (10) @(posedge sim_clk);
        #1;
        chk_pos("hold", 178, 99, 1, 2);

        // free fall: 20 more ticks, speed saturates at 15
        exp_spd = 1;
        exp_y   = 99;
        for (int k = 2; k <= 21; k++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b1);
            exp_y   = exp_y + exp_spd;
            exp_spd = (exp_spd >= 15) ? 15 : exp_spd + 1;
            chk("fall.yspd", 32'(yspd), 32'(exp_spd));
        end
        chk_pos("fall21", 218, 294, 15, 2);

        // respawn is ignored without tick, applied with it
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        chk_pos("resp_notick", 218, 294, 15, 2);
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        chk_pos("resp", 176, 99, 0, 2);

        // five free ticks -> y=109 yspd=5, then land: yn=114 -> 114-15-1=98
        repeat (5) step(4'b0000, 1'b0, 1'b0, 1'b1);
        chk_pos("prefall", 186, 109, 5, 2);
        step(4'b0010, 1'b0, 1'b0, 1'b1);
        chk_pos("land", 188, 98, 0, 0);
        chk("land.pulse", 32'(landed), 32'd1);
        @(posedge sim_clk);
        #1;
        chk("land.pulse_end", 32'(landed), 32'd0);

        step(4'b0010, 1'b0, 1'b0, 1'b1);
        chk_pos("ground", 190, 98, 0, 0);
        // jump beats floor contact
        step(4'b0010, 1'b1, 1'b0, 1'b1);
        chk_pos("jump", 192, 98, 9, 1);
        chk("jump.ydir", 32'(ydir), 32'd1);
        // floor contact ignored while rising
        step(4'b0010, 1'b0, 1'b0, 1'b1);
        chk_pos("rise", 194, 89, 8, 1);
        // ceiling: yn=81, (81-35)&31=14 -> 81+18=99
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        chk_pos("bonk", 196, 99, 0, 2);
        chk("bonk.ydir", 32'(ydir), 32'd0);

        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        chk_pos("pre_wall", 200, 100, 2, 2);
        // right wall + floor: x 202-26-1=175, y 102-3-1=98
        step(4'b0011, 1'b0, 1'b0, 1'b1);
        chk_pos("wall_r", 175, 98, 0, 0);
        chk("wall_r.xdir", 32'(xdir), 32'd0);
        chk("wall_r.landed", 32'(landed), 32'd1);
        // left wall + floor: x 173+(32-29)=176
        step(4'b0110, 1'b0, 1'b0, 1'b1);
        chk_pos("wall_l", 176, 98, 0, 0);
        chk("wall_l.xdir", 32'(xdir), 32'd1);
        chk("wall_l.landed", 32'(landed), 32'd0);

        // walk off ledge, jump in mid-air (ceiling ignored in FALL), then land
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        chk_pos("ledge", 178, 98, 0, 2);
        step(4'b1000, 1'b1, 1'b0, 1'b1);
        chk_pos("air_jump", 180, 98, 1, 2);
        step(4'b0010, 1'b0, 1'b0, 1'b1);
`ifdef ENTITY_JUMP_BUFFER_EN
        chk_pos("buf_land", 182, 98, 9, 1);
`else
        chk_pos("buf_land", 182, 98, 0, 0);
`endif
        chk("buf_land.landed", 32'(landed), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
